// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Counts spikes on a 1-bit stream over a programmable window of clock
// cycles and tracks the most recent inter-spike interval (ISI). Each
// completed window's rate and ISI are offered on a valid/ready interface.
//
// Optional build macro:
//   SPIKE_EDGE_DET_EN - a spike is a 0->1 transition of spike_in (registered
//                       previous sample) instead of every high sample.
module spike_rate_decoder #(
    parameter int unsigned WIN_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);
    localparam logic [WIN_W:0]   WIN_ONE = (WIN_W + 1)'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    // Window counter is one bit wider so window_len=0 can load 2^WIN_W.
    logic [WIN_W:0]   r_win_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [ISI_W-1:0] r_isi;
    logic             r_seen;
    logic [ISI_W-1:0] r_last_isi;

    logic [CNT_W-1:0] r_rate;
    logic [ISI_W-1:0] r_isi_out;
    logic             r_valid;
    logic             r_overrun;

    logic [WIN_W:0]   w_win_load;
    logic             w_start;
    logic             w_active;
    logic             w_last;
    logic             w_spike;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ISI_W-1:0] w_isi_inc;
    logic [ISI_W-1:0] w_last_isi_nxt;
    logic             w_accept;
    logic             w_load;

    // Window length decode: zero selects the full 2^WIN_W span.
    assign w_win_load = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}}
                                           : {1'b0, window_len};

    assign w_start  = (r_state == ST_IDLE)  && enable;
    assign w_active = (r_state == ST_COUNT) && enable;
    assign w_last   = w_active && (r_win_cnt == WIN_ONE);

`ifdef SPIKE_EDGE_DET_EN
    logic r_prev;

    // Previous spike_in sample for rising-edge detection; cleared on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else if (w_start) begin
            r_prev <= 1'b0;
        end else if (w_active) begin
            r_prev <= spike_in;
        end
    end

    assign w_spike = spike_in & ~r_prev;
`else
    assign w_spike = spike_in;
`endif

    // Saturating increments for the spike count and the interval counter.
    assign w_cnt_nxt = (w_spike && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
    assign w_isi_inc = (r_isi != ISI_MAX) ? r_isi + 1'b1 : r_isi;

    // A spike closes an interval only if an earlier spike opened one.
    assign w_last_isi_nxt = (w_spike && r_seen) ? r_isi : r_last_isi;

    assign w_accept = r_valid & out_ready;
    assign w_load   = w_last & (~r_valid | w_accept);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enable starts a window, dropping it aborts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable)  w_state_nxt = ST_COUNT;
            ST_COUNT: if (!enable) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Window counter, spike count and ISI tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_cnt      <= '0;
            r_isi      <= '0;
            r_seen     <= 1'b0;
            r_last_isi <= '0;
        end else if (w_start) begin
            r_win_cnt  <= w_win_load;
            r_cnt      <= '0;
            r_isi      <= '0;
            r_seen     <= 1'b0;
            r_last_isi <= '0;
        end else if (w_active) begin
            r_isi      <= w_spike ? ISI_ONE : w_isi_inc;
            r_last_isi <= w_last_isi_nxt;
            if (w_spike) begin
                r_seen <= 1'b1;
            end
            if (w_last) begin
                // Next window begins on the following cycle with a fresh length.
                r_win_cnt <= w_win_load;
                r_cnt     <= '0;
            end else begin
                r_win_cnt <= r_win_cnt - 1'b1;
                r_cnt     <= w_cnt_nxt;
            end
        end
    end

    // Result holding register, valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate    <= '0;
            r_isi_out <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_rate    <= w_cnt_nxt;
                r_isi_out <= w_last_isi_nxt;
                r_valid   <= 1'b1;
            end else if (w_accept) begin
                r_valid   <= 1'b0;
            end
            if (w_last && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rate_out  = r_rate;
    assign isi_out   = r_isi_out;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state == ST_COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder
// Directed table, corner-case sequences and randomized traffic, every cycle
// compared against a timestamp-based reference model.
// Honours SPIKE_EDGE_DET_EN the same way as the design.
module tb_spike_rate_decoder;

    localparam int CNT_MAX = 255;
    localparam int ISI_MAX = 255;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic [7:0] rate_out;
    logic [7:0] isi_out;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       busy;

    int total;
    int bad;

    spike_rate_decoder #(
        .WIN_W(8),
        .CNT_W(8),
        .ISI_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .spike_in  (spike_in),
        .window_len(window_len),
        .rate_out  (rate_out),
        .isi_out   (isi_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: spikes are timestamps; rate is the number of spikes
    // stamped inside the window, ISI is the gap between the last two stamps.
    int m_time;
    bit m_busy;
    int m_n;
    int m_pos;
    int q_win[$];
    bit m_have;
    int m_last_t;
    int m_last_isi;
    bit m_valid;
    int m_rate;
    int m_isi;
    bit m_ovr;
`ifdef SPIKE_EDGE_DET_EN
    bit m_prev;
`endif

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit s,
                              input logic [7:0] w, input bit rd);
        bit acc;
        bit pub;
        bit sv;
        int pr;
        int pi;
        pub = 1'b0;
        pr  = 0;
        pi  = 0;
        if (r) begin
            m_busy = 0; m_valid = 0; m_rate = 0; m_isi = 0; m_ovr = 0;
            q_win.delete(); m_have = 0; m_last_isi = 0; m_pos = 0;
`ifdef SPIKE_EDGE_DET_EN
            m_prev = 0;
`endif
        end else begin
            acc = m_valid && rd;
            if (!m_busy) begin
                if (e) begin
                    m_busy = 1;
                    m_n = (w == 0) ? 256 : int'(w);
                    m_pos = 0;
                    q_win.delete();
                    m_have = 0;
                    m_last_isi = 0;
`ifdef SPIKE_EDGE_DET_EN
                    m_prev = 0;
`endif
                end
            end else if (!e) begin
                m_busy = 0;
            end else begin
`ifdef SPIKE_EDGE_DET_EN
                sv = s && !m_prev;
                m_prev = s;
`else
                sv = s;
`endif
                if (sv) begin
                    if (m_have) m_last_isi = imin(m_time - m_last_t, ISI_MAX);
                    m_last_t = m_time;
                    m_have = 1;
                    q_win.push_back(m_time);
                end
                m_pos++;
                if (m_pos == m_n) begin
                    pub = 1;
                    pr = imin(q_win.size(), CNT_MAX);
                    pi = m_last_isi;
                    q_win.delete();
                    m_pos = 0;
                    m_n = (w == 0) ? 256 : int'(w);
                end
            end
            if (pub && (!m_valid || acc)) begin
                m_valid = 1; m_rate = pr; m_isi = pi;
            end else if (pub) begin
                m_ovr = 1;
            end else if (acc) begin
                m_valid = 0;
            end
        end
        m_time++;
    endtask

    // One clock: drive inputs, clock, advance the model, compare all outputs.
    task automatic step(input bit r, input bit e, input bit s,
                        input logic [7:0] w, input bit rd);
        rst = r; enable = e; spike_in = s; window_len = w; out_ready = rd;
        @(posedge clk);
        #1;
        model_edge(r, e, s, w, rd);
        chk("m_valid",   out_valid, m_valid);
        chk("m_rate",    rate_out,  m_rate);
        chk("m_isi",     isi_out,   m_isi);
        chk("m_overrun", overrun,   m_ovr);
        chk("m_busy",    busy,      m_busy);
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        bit         sp;
        logic [7:0] wl;
        bit         rdy;
        bit         e_valid;
        int         e_rate;
        int         e_isi;
        bit         e_ovr;
        bit         e_busy;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit e, input bit s, input int w,
                                input bit rd, input bit ev, input int er, input int ei,
                                input bit eo, input bit eb);
        vec_t v;
        v.rst = r; v.en = e; v.sp = s; v.wl = 8'(w); v.rdy = rd;
        v.e_valid = ev; v.e_rate = er; v.e_isi = ei; v.e_ovr = eo; v.e_busy = eb;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        int exp_rate;
        int exp_isi;
        bit sp;
        int dens;
        int rdyp;
        logic [7:0] wl;

        total = 0; bad = 0; m_time = 0; m_n = 1;
        rst = 1; enable = 0; spike_in = 0; window_len = 8'd10; out_ready = 0;
        model_edge(1, 0, 0, 8'd10, 0);

        // 10-cycle window, spikes on window cycles 2, 5, 8.
        tbl[0] = mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 10, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tbl[2 + i] = mk(0, 1, (i == 2 || i == 5 || i == 8), 10, 1,
                            (i == 9), (i == 9) ? 3 : 0, (i == 9) ? 3 : 0, 0, 1);
        end
        tbl[12] = mk(0, 1, 0, 10, 1, 0, 3, 3, 0, 1);
        tbl[13] = mk(0, 0, 0, 10, 1, 0, 3, 3, 0, 0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].sp, tbl[i].wl, tbl[i].rdy);
            chk("tbl_valid",   out_valid, tbl[i].e_valid);
            chk("tbl_rate",    rate_out,  tbl[i].e_rate);
            chk("tbl_isi",     isi_out,   tbl[i].e_isi);
            chk("tbl_overrun", overrun,   tbl[i].e_ovr);
            chk("tbl_busy",    busy,      tbl[i].e_busy);
        end

        // Continuous spikes, 4-cycle windows, results back to back.
        step(1, 0, 0, 8'd4, 1);
        step(0, 1, 1, 8'd4, 1);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 1, 8'd4, 1);
`ifdef SPIKE_EDGE_DET_EN
            exp_rate = (k == 4) ? 1 : 0;
            exp_isi  = 0;
`else
            exp_rate = 4;
            exp_isi  = 1;
`endif
            chk("cont_valid", out_valid, (k % 4 == 0));
            if (k % 4 == 0) begin
                chk("cont_rate", rate_out, exp_rate);
                chk("cont_isi",  isi_out,  exp_isi);
            end
        end

        // window_len=0 spans 256 cycles; count saturates.
        step(1, 0, 0, 8'd0, 1);
        step(0, 1, 1, 8'd0, 1);
        for (int k = 1; k <= 256; k++) begin
            step(0, 1, 1, 8'd0, 1);
            if (k == 255) chk("sat_early_valid", out_valid, 0);
        end
        chk("sat_valid", out_valid, 1);
`ifdef SPIKE_EDGE_DET_EN
        chk("sat_rate", rate_out, 1);
`else
        chk("sat_rate", rate_out, 255);
`endif

        // Stalled consumer: second result dropped, overrun sticks.
        step(1, 0, 0, 8'd3, 0);
        step(0, 1, 0, 8'd3, 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, (k == 1 || k == 3 || k == 5), 8'd3, 0);
            if (k == 3) begin
                chk("ovr_first_valid", out_valid, 1);
                chk("ovr_first_rate",  rate_out,  2);
                chk("ovr_first_isi",   isi_out,   2);
                chk("ovr_not_yet",     overrun,   0);
            end
            if (k == 6) begin
                chk("ovr_held_rate", rate_out, 2);
                chk("ovr_set",       overrun,  1);
            end
        end
        step(0, 0, 0, 8'd3, 1);
        chk("ovr_drain_valid", out_valid, 0);
        chk("ovr_sticky",      overrun,   1);
        chk("ovr_drain_busy",  busy,      0);

        // Abort mid-window, then a fresh window forgets earlier spikes.
        step(1, 0, 0, 8'd10, 1);
        step(0, 1, 0, 8'd10, 1);
        for (int k = 1; k <= 4; k++) step(0, 1, (k == 1 || k == 3), 8'd10, 1);
        step(0, 0, 0, 8'd10, 1);
        chk("abort_busy",  busy,      0);
        chk("abort_valid", out_valid, 0);
        step(0, 1, 0, 8'd10, 1);
        for (int k = 1; k <= 10; k++) step(0, 1, (k == 4), 8'd10, 1);
        chk("fresh_valid", out_valid, 1);
        chk("fresh_rate",  rate_out,  1);
        chk("fresh_isi",   isi_out,   0);

        // Reset while a result is held and a window is in progress.
        step(0, 0, 0, 8'd3, 1);
        step(0, 1, 0, 8'd3, 0);
        for (int k = 1; k <= 4; k++) step(0, 1, 1, 8'd3, 0);
        chk("pre_rst_valid", out_valid, 1);
        step(1, 1, 1, 8'd3, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rate",  rate_out,  0);
        chk("rst_isi",   isi_out,   0);
        chk("rst_busy",  busy,      0);

        // Randomized traffic against the model.
        dens = 50; rdyp = 70; wl = 8'd5;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                dens = int'($urandom_range(0, 100));
                rdyp = int'($urandom_range(0, 100));
            end
            if ($urandom_range(0, 19) == 0) begin
                wl = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            end
            sp = ($urandom_range(0, 99) < dens);
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 149) != 0),
                 sp, wl,
                 ($urandom_range(0, 99) < rdyp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
